if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage. It owns the fetch PC and issues word requests to instruction memory over a req/ready/rvalid handshake.
- Returned instructions are buffered in a small FIFO and presented to the IF/ID register as {PC+4, Instruction, valid}.
- Honours the hazard freeze and redirects on a taken branch from EXE, discarding any wrong-path responses.

---
 rtl/if_fetch_stage_if.sv | 10 +
 rtl/if_fetch_stage.sv | 66 ++++++
 tb/tb_if_fetch_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/response channel between fetch stage and memory
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: credit-limited instruction fetch with response buffer, freeze hold and branch redirect
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             Branch_taken,
  input  logic [31:0]      Branch_Address,
  if_fetch_stage_if.master imem,
  output logic [31:0]      PC,
  output logic [31:0]      Instruction,
  output logic             valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_inflight, r_drop_cnt, r_count;
  logic [PW-1:0] r_wr, r_rd, r_aq_wr, r_aq_rd;
  logic [31:0]   r_aq   [DEPTH];
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_word [DEPTH];
  logic [CW:0]   w_used;
  logic          w_accept, w_resp, w_drop, w_push, w_pop;
  assign w_used      = {1'b0, r_inflight} + {1'b0, r_count};
  assign imem.req    = rst & ~Branch_taken & (w_used < (CW+1)'(DEPTH));
  assign imem.addr   = r_fetch_pc;
  assign w_accept    = imem.req & imem.ready;
  assign w_resp      = imem.rvalid & (r_inflight != '0);
  assign w_drop      = w_resp & (r_drop_cnt != '0);
  assign w_push      = w_resp & ~w_drop & ~Branch_taken;
  assign w_pop       = valid & ~freeze & ~Branch_taken;
  assign valid       = r_count != '0;
  assign PC          = valid ? r_addr[r_rd] + 32'd4 : '0;
  assign Instruction = valid ? r_word[r_rd] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_aq_wr    <= '0;
      r_aq_rd    <= '0;
    end else begin
      r_fetch_pc <= Branch_taken ? Branch_Address : w_accept ? r_fetch_pc + 32'd4 : r_fetch_pc;
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp);
      // every outstanding request is wrong-path after a redirect, so the drop count tracks inflight
      r_drop_cnt <= Branch_taken ? r_inflight - CW'(w_resp) : r_drop_cnt - CW'(w_drop);
      r_count    <= Branch_taken ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      r_wr       <= r_wr + PW'(w_push);
      r_rd       <= Branch_taken ? r_wr : r_rd + PW'(w_pop);
      r_aq_wr    <= r_aq_wr + PW'(w_accept);
      r_aq_rd    <= r_aq_rd + PW'(w_resp);
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept) r_aq[r_aq_wr] <= r_fetch_pc;
    if (w_push) begin
      r_addr[r_wr] <= r_aq[r_aq_rd];
      r_word[r_wr] <= imem.rdata;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized bench comparing the fetch stage against an epoch-tagged request/buffer model
module tb_if_fetch_stage;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef struct {logic [31:0] addr; int epoch;} req_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} ent_t;
  logic        clk = 0;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] Branch_Address;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;
  if_fetch_stage_if imem();
  if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(Branch_taken),
    .Branch_Address(Branch_Address), .imem(imem), .PC(PC),
    .Instruction(Instruction), .valid(valid)
  );
  always #5 clk = ~clk;
  int          total = 0;
  int          bad = 0;
  int          epoch = 0;
  logic [31:0] epa = RESET_PC;
  req_t        pending[$];
  ent_t        q[$];
  logic [31:0] log_pc[$];
  logic        obs_valid;
  logic [31:0] obs_pc, obs_ins;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a < 32'h200 ? a : a ^ 32'hC3C3_0000;
  endfunction
  task automatic step(input bit r, input bit br, input logic [31:0] ba, input bit fz, input bit rdy, input bit rv);
    bit   exp_req;
    req_t h;
    @(posedge clk); #1;
    rst = r; Branch_taken = br; Branch_Address = ba; freeze = fz; imem.ready = rdy;
    if (!r) begin
      pending.delete(); q.delete(); epa = RESET_PC;
    end
    imem.rvalid = rv;
    imem.rdata  = pending.size() > 0 ? mem(pending[0].addr) : $urandom();
    #1;
    exp_req = r && !br && (pending.size() + q.size() < DEPTH);
    chk("req", 32'(imem.req), 32'(exp_req));
    if (exp_req) chk("addr", imem.addr, epa);
    chk("valid", 32'(valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("pc", PC, q[0].addr + 32'd4);
      chk("ins", Instruction, q[0].data);
    end else if (!r) begin
      chk("rst_pc", PC, 32'h0);
      chk("rst_ins", Instruction, 32'h0);
    end
    obs_valid = valid; obs_pc = PC; obs_ins = Instruction;
    if (r) begin
      if (q.size() > 0 && !fz && !br) begin
        log_pc.push_back(q[0].addr + 32'd4);
        void'(q.pop_front());
      end
      if (rv && pending.size() > 0) begin
        h = pending.pop_front();
        if (!br && h.epoch == epoch) q.push_back('{h.addr, imem.rdata});
      end
      if (br) begin
        q.delete(); epoch++; epa = ba;
      end else if (imem.req && rdy) begin
        pending.push_back('{epa, epoch}); epa += 32'd4;
      end
      chk("credit", 32'(pending.size() + q.size() <= DEPTH), 32'd1);
    end
  endtask
  initial begin
    rst = 0; freeze = 0; Branch_taken = 0; Branch_Address = 0;
    imem.ready = 0; imem.rvalid = 0; imem.rdata = 0;
    repeat (3) step(0, 0, 0, 0, 0, 1);
    log_pc.delete();
    repeat (10) step(1, 0, 0, 0, 1, 1);
    chk("seq0", log_pc[0], 32'd4);
    chk("seq1", log_pc[1], 32'd8);
    chk("seq2", log_pc[2], 32'd12);
    repeat (5) step(1, 0, 0, 1, 1, 1);
    repeat (6) step(1, 0, 0, 0, 1, 1);
    repeat (4) step(1, 0, 0, 0, 1, 0);
    chk("two_inflight", 32'(pending.size()), 32'd2);
    step(1, 1, 32'h100, 0, 1, 0);
    obs_valid = 0;
    for (int i = 0; i < 12 && !obs_valid; i++) step(1, 0, 0, 0, 1, 1);
    chk("br_valid", 32'(obs_valid), 32'd1);
    chk("br_pc", obs_pc, 32'h104);
    chk("br_ins", obs_ins, 32'h100);
    repeat (4) step(1, 0, 0, 0, 1, 0);
    step(1, 1, 32'h180, 0, 1, 1);
    repeat (6) step(1, 0, 0, 0, 1, 1);
    repeat (4) step(1, 0, 0, 0, 1, 0);
    step(1, 1, 32'h300, 0, 1, 0);
    step(1, 1, 32'h400, 0, 1, 1);
    repeat (8) step(1, 0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 1);
    repeat (6) step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(299) != 0, $urandom_range(9) == 0, {$urandom_range(32'h3FFF_FFFF), 2'b00},
           $urandom_range(3) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
